// File: rtl/rr_resource_arbiter.sv
// rr_resource_arbiter: round-robin owner select for one shared resource.
// Registered one-hot grant, held until release or hold timeout.
module rr_resource_arbiter #(
  parameter int N        = 4,
  parameter int HOLD_W   = 4,
  parameter int HOLD_MAX = 15,
  localparam int IDW     = $clog2(N)
) (
  input  logic           CK,
  input  logic           R,
  input  logic [N-1:0]   REQ,
  output logic [N-1:0]   GNT,
  output logic [IDW-1:0] GNT_ID,
  output logic           BUSY,
  output logic           TOUT
);

  localparam bit TO_EN = (HOLD_MAX != 0);
  localparam logic [HOLD_W-1:0] CNT_LAST =
    HOLD_W'(TO_EN ? HOLD_MAX - 1 : 0);
  localparam logic [IDW-1:0] ID_LAST = IDW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [N-1:0]      gnt;
  logic [N-1:0]      gnt_nx;
  logic [IDW-1:0]    gnt_id;
  logic [IDW-1:0]    id_nx;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    ptr_nx;
  logic [IDW-1:0]    win;
  logic [IDW-1:0]    cand;
  logic [IDW-1:0]    nxt;
  logic [HOLD_W-1:0] cnt;
  logic [HOLD_W-1:0] cnt_nx;
  logic              tout;
  logic              tout_nx;
  logic              found;
  logic              expire;

  // First requester at or after ptr, wrapping at N-1 so
  // non-power-of-2 N never produces an index >= N.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = ptr;
    for (int k = 0; k < N; k++) begin
      if (!found && REQ[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = (cand == ID_LAST) ? '0 : cand + 1'b1;
    end
  end

  assign nxt    = (gnt_id == ID_LAST) ? '0 : gnt_id + 1'b1;
  assign expire = TO_EN && (cnt == CNT_LAST);

  always_ff @(posedge CK) begin
    if (R) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= '0;
      cnt    <= '0;
      tout   <= 1'b0;
    end else begin
      state  <= state_nx;
      gnt    <= gnt_nx;
      gnt_id <= id_nx;
      ptr    <= ptr_nx;
      cnt    <= cnt_nx;
      tout   <= tout_nx;
    end
  end

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    id_nx    = gnt_id;
    ptr_nx   = ptr;
    cnt_nx   = cnt;
    tout_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_nx      = '0;
          gnt_nx[win] = 1'b1;
          id_nx       = win;
          cnt_nx      = '0;
          state_nx    = GRANT;
        end
      end
      GRANT: begin
        // Every exit goes through IDLE: one dead cycle on the mux.
        if (!REQ[gnt_id]) begin
          gnt_nx   = '0;
          ptr_nx   = nxt;
          state_nx = IDLE;
        end else if (expire) begin
          gnt_nx   = '0;
          ptr_nx   = nxt;
          tout_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    GNT    = gnt;
    GNT_ID = gnt_id;
    BUSY   = |gnt;
    TOUT   = tout;
  end

endmodule
